// File: rtl/cam_readout_if.sv
// Bus between the readout controller, the CAM array and the downstream word sink.
// master = controller side, slave = array/sink side.
interface cam_readout_if #(
    parameter int DATA_WIDTH     = 4,
    parameter int DATA_DEPTH     = 4,
    parameter int ADDR_WIDTH_CAM = 8,
    parameter int OUT_WIDTH      = 4
) ();
    logic [2:0]                input_mode;
    logic [ADDR_WIDTH_CAM-1:0] addr_output_Row;
    logic [ADDR_WIDTH_CAM-1:0] addr_output_Col;
    logic [DATA_WIDTH-1:0]     Q_out_row;
    logic [DATA_DEPTH-1:0]     Q_out_col;
    logic [OUT_WIDTH-1:0]      data_out;
    logic                      data_valid;
    logic                      data_ready;
    logic                      data_last;

    modport master (
        output input_mode, addr_output_Row, addr_output_Col,
        output data_out, data_valid, data_last,
        input  Q_out_row, Q_out_col, data_ready
    );

    modport slave (
        input  input_mode, addr_output_Row, addr_output_Col,
        input  data_out, data_valid, data_last,
        output Q_out_row, Q_out_col, data_ready
    );
endinterface

// File: rtl/cam_readout.sv
// CAM readout sequencer: scans every row or every column of the array, waits out the
// two-clock read latency and streams each captured word downstream with valid/ready.
module cam_readout #(
    parameter int         DATA_WIDTH     = 4,
    parameter int         DATA_DEPTH     = 4,
    parameter int         ADDR_WIDTH_CAM = 8,
    parameter int         OUT_WIDTH      = 4,
    parameter logic [2:0] RowxRow        = 3'd1,
    parameter logic [2:0] ColxCol        = 3'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              col_sel,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    cam_readout_if.master     bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        SEND    = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH_CAM-1:0] ROW_PARK = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
    localparam logic [ADDR_WIDTH_CAM-1:0] COL_PARK = ADDR_WIDTH_CAM'(DATA_WIDTH + 3);
    localparam logic [ADDR_WIDTH_CAM-1:0] ROW_LAST = ADDR_WIDTH_CAM'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH_CAM-1:0] COL_LAST = ADDR_WIDTH_CAM'(DATA_WIDTH - 1);

    state_t                    state_reg, state_next;
    logic [ADDR_WIDTH_CAM-1:0] idx_reg, idx_next;
    logic                      col_reg, col_next;
    logic [OUT_WIDTH-1:0]      data_out_reg, data_out_next;
    logic [2:0]                mode_reg, mode_next;
    logic [ADDR_WIDTH_CAM-1:0] addr_row_reg, addr_row_next;
    logic [ADDR_WIDTH_CAM-1:0] addr_col_reg, addr_col_next;
    logic                      valid_reg, valid_next;
    logic                      last_reg, last_next;
    logic                      busy_reg, busy_next;
    logic                      done_reg, done_next;

    logic [OUT_WIDTH-1:0]      row_word;
    logic [OUT_WIDTH-1:0]      col_word;
    logic [ADDR_WIDTH_CAM-1:0] last_idx;
    logic [ADDR_WIDTH_CAM-1:0] last_idx_next;
    logic                      scanning_next;

    // Zero-extend both array readout buses to the output word width.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_WIDTH; gi = gi + 1) begin : g_ext
            if (gi < DATA_WIDTH) begin : g_row_bit
                assign row_word[gi] = bus.Q_out_row[gi];
            end else begin : g_row_pad
                assign row_word[gi] = 1'b0;
            end
            if (gi < DATA_DEPTH) begin : g_col_bit
                assign col_word[gi] = bus.Q_out_col[gi];
            end else begin : g_col_pad
                assign col_word[gi] = 1'b0;
            end
        end
    endgenerate

    assign last_idx = col_reg ? COL_LAST : ROW_LAST;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        col_next      = col_reg;
        data_out_next = data_out_reg;

        // Abort wins over everything else, including a SEND handshake in the same cycle.
        if (abort && (state_reg != IDLE)) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        col_next   = col_sel;
                        idx_next   = '0;
                        state_next = ISSUE;
                    end
                end
                ISSUE:   state_next = WAIT;
                WAIT:    state_next = CAPTURE;
                CAPTURE: begin
                    data_out_next = col_reg ? col_word : row_word;
                    state_next    = SEND;
                end
                SEND: begin
                    if (bus.data_ready) begin
                        if (idx_reg != last_idx) begin
                            idx_next   = idx_reg + ADDR_WIDTH_CAM'(1);
                            state_next = ISSUE;
                        end else begin
                            state_next = FIN;
                        end
                    end
                end
                FIN:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        // Outputs are derived from the next state so that they leave the flops aligned
        // with the state they describe.
        scanning_next = (state_next == ISSUE) || (state_next == WAIT) ||
                        (state_next == CAPTURE) || (state_next == SEND);
        last_idx_next = col_next ? COL_LAST : ROW_LAST;
        mode_next     = scanning_next ? (col_next ? ColxCol : RowxRow) : 3'd0;
        addr_row_next = (scanning_next && !col_next) ? idx_next : ROW_PARK;
        addr_col_next = (scanning_next && col_next) ? idx_next : COL_PARK;
        valid_next    = (state_next == SEND);
        last_next     = (state_next == SEND) && (idx_next == last_idx_next);
        busy_next     = (state_next != IDLE);
        done_next     = (state_next == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            col_reg      <= 1'b0;
            data_out_reg <= '0;
            mode_reg     <= 3'd0;
            addr_row_reg <= ROW_PARK;
            addr_col_reg <= COL_PARK;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            col_reg      <= col_next;
            data_out_reg <= data_out_next;
            mode_reg     <= mode_next;
            addr_row_reg <= addr_row_next;
            addr_col_reg <= addr_col_next;
            valid_reg    <= valid_next;
            last_reg     <= last_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign bus.input_mode      = mode_reg;
    assign bus.addr_output_Row = addr_row_reg;
    assign bus.addr_output_Col = addr_col_reg;
    assign bus.data_out        = data_out_reg;
    assign bus.data_valid      = valid_reg;
    assign bus.data_last       = last_reg;
    assign busy                = busy_reg;
    assign done                = done_reg;
endmodule

// File: tb/tb_cam_readout.sv
// Randomized and directed bench for cam_readout; a transaction-level model predicts
// the word stream, done pulse, scan latency and idle/parked bus values.
module tb_cam_readout;
    localparam int DW = 4;
    localparam int DD = 4;
    localparam int AW = 8;
    localparam int OW = 4;
    localparam logic [AW-1:0] ROW_PARK = AW'(DD + 3);
    localparam logic [AW-1:0] COL_PARK = AW'(DW + 3);

    logic clk = 1'b0;
    logic rst, start, col_sel, abort, busy, done;

    cam_readout_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH_CAM(AW), .OUT_WIDTH(OW)) bus ();

    cam_readout #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH_CAM(AW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .col_sel(col_sel), .abort(abort),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Array model: contents per row and per column, two-clock read latency.
    logic [DW-1:0] row_mem [DD];
    logic [DD-1:0] col_mem [DW];
    logic [DW-1:0] row_s1;
    logic [DD-1:0] col_s1;

    always @(posedge clk) begin
        row_s1        <= (bus.addr_output_Row < AW'(DD)) ? row_mem[bus.addr_output_Row[1:0]] : '0;
        col_s1        <= (bus.addr_output_Col < AW'(DW)) ? col_mem[bus.addr_output_Col[1:0]] : '0;
        bus.Q_out_row <= row_s1;
        bus.Q_out_col <= col_s1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Transaction-level reference state.
    bit            active = 1'b0;
    bit            fin = 1'b0;
    bit            scan_col = 1'b0;
    bit            all_ready = 1'b0;
    int            n = 0;
    int            start_cyc = 0;
    int            cycle_no = 0;
    logic [OW-1:0] q [$];
    logic          prev_valid = 1'b0;
    logic [OW-1:0] prev_data = '0;

    task automatic cyc(input logic st, input logic cs, input logic ab, input logic rs, input logic rd);
        bit done_exp;
        start = st; col_sel = cs; abort = ab; rst = rs; bus.data_ready = rd;
        @(posedge clk);
        #1;
        cycle_no++;
        done_exp = 1'b0;
        if (rs) begin
            active = 1'b0; fin = 1'b0; q.delete();
            check("rst_valid", 32'(bus.data_valid), 32'(0));
            check("rst_last",  32'(bus.data_last),  32'(0));
            check("rst_busy",  32'(busy),           32'(0));
            check("rst_done",  32'(done),           32'(0));
            check("rst_data",  32'(bus.data_out),   32'(0));
            check("rst_mode",  32'(bus.input_mode), 32'(0));
            check("rst_arow",  32'(bus.addr_output_Row), 32'(ROW_PARK));
            check("rst_acol",  32'(bus.addr_output_Col), 32'(COL_PARK));
        end else begin
            if (fin) begin
                active = 1'b0; fin = 1'b0;
            end else if (active && ab) begin
                active = 1'b0; q.delete();
            end else if (active) begin
                if (prev_valid && rd) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        fin = 1'b1; done_exp = 1'b1;
                    end
                end else if (prev_valid) begin
                    all_ready = 1'b0;
                    check("hold_valid", 32'(bus.data_valid), 32'(1));
                    check("hold_data",  32'(bus.data_out),   32'(prev_data));
                end
            end else if (st) begin
                active = 1'b1; scan_col = cs; all_ready = 1'b1;
                start_cyc = cycle_no;
                n = cs ? DW : DD;
                for (int i = 0; i < n; i++)
                    q.push_back(cs ? OW'(col_mem[i]) : OW'(row_mem[i]));
            end
            check("busy", 32'(busy), 32'(active));
            check("done", 32'(done), 32'(done_exp));
            if (done_exp && all_ready)
                check("latency", 32'(cycle_no - start_cyc + 1), 32'(4 * n + 1));
            if (!active || fin) begin
                check("idle_mode",  32'(bus.input_mode), 32'(0));
                check("idle_arow",  32'(bus.addr_output_Row), 32'(ROW_PARK));
                check("idle_acol",  32'(bus.addr_output_Col), 32'(COL_PARK));
                check("idle_valid", 32'(bus.data_valid), 32'(0));
            end else begin
                check("mode", 32'(bus.input_mode), scan_col ? 32'(2) : 32'(1));
                check("arow", 32'(bus.addr_output_Row), scan_col ? 32'(ROW_PARK) : 32'(n - q.size()));
                check("acol", 32'(bus.addr_output_Col), scan_col ? 32'(n - q.size()) : 32'(COL_PARK));
                if (bus.data_valid) begin
                    check("word", 32'(bus.data_out),  32'(q[0]));
                    check("last", 32'(bus.data_last), 32'(q.size() == 1));
                end else begin
                    check("last_idle", 32'(bus.data_last), 32'(0));
                end
            end
        end
        prev_valid = bus.data_valid;
        prev_data  = bus.data_out;
        $display("cyc %0d st=%0b cs=%0b ab=%0b rst=%0b rdy=%0b | busy=%0b valid=%0b data=%0h last=%0b done=%0b",
                 cycle_no, st, cs, ab, rs, rd, busy, bus.data_valid, bus.data_out, bus.data_last, done);
    endtask

    // One scan from IDLE; optionally stalls a given word for 5 cycles or aborts after k cycles.
    task automatic run_scan(input logic cs, input int stall_word, input int abort_after);
        int k;
        int lowcnt;
        logic rd;
        logic ab;
        k = 0; lowcnt = 0;
        cyc(1'b1, cs, 1'b0, 1'b0, 1'b1);
        while (active && k < 300) begin
            k++;
            rd = 1'b1; ab = 1'b0;
            if (stall_word >= 0 && prev_valid && (n - q.size()) == stall_word && lowcnt < 5) begin
                rd = 1'b0; lowcnt++;
            end
            if (abort_after > 0 && k == abort_after) ab = 1'b1;
            cyc(1'b0, cs, ab, 1'b0, rd);
        end
        if (active) check("scan_timeout", 32'(active), 32'(0));
    endtask

    initial begin
        int dones;
        start = 1'b0; col_sel = 1'b0; abort = 1'b0; rst = 1'b1; bus.data_ready = 1'b1;
        row_mem[0] = 4'h3; row_mem[1] = 4'hA; row_mem[2] = 4'h5; row_mem[3] = 4'hF;
        col_mem[0] = 4'hF; col_mem[1] = 4'hB; col_mem[2] = 4'h6; col_mem[3] = 4'hA;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        run_scan(1'b0, -1, 0);          // row scan, ready held high
        run_scan(1'b1, -1, 0);          // column scan
        run_scan(1'b0, 1, 0);           // word 1 stalled for 5 cycles
        run_scan(1'b0, -1, 10);         // abort in WAIT of index 2
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_scan(1'b0, -1, 0);          // full scan after the abort

        // Reset in SEND with a start issued while busy.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Start while busy mid-scan must not restart or extend the scan.
        dones = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc((i % 3) == 0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (done) dones++;
        end
        check("one_done", 32'(dones), 32'(1));

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if (!active && $urandom_range(0, 3) == 0) begin
                for (int r = 0; r < DD; r++) row_mem[r] = DW'($urandom);
                for (int c = 0; c < DW; c++) col_mem[c] = DD'($urandom);
            end
            cyc($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 79) == 0,
                $urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
